// File: rtl/fetch_unit.sv
// PC / fetch sequencer in front of a one-cycle-latency instruction memory.
// Tracks which PC is on the memory output, squashes wrong-path words and halts after LAST_ADDR.
module fetch_unit #(
  parameter int ADDR_WIDTH = 4,
  parameter int RESET_ADDR = 0,
  parameter int LAST_ADDR  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirectTarget,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [ADDR_WIDTH-1:0] instrPc,
  output logic                  instrValid,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC  = ADDR_WIDTH'(RESET_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(LAST_ADDR);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [ADDR_WIDTH-1:0] pc;
  logic [1:0]            state;
  logic                  hold;
  logic                  tgt_ok;

  // Stalls have no effect once halted; both address sources are equal there anyway.
  assign hold   = stall && (state != HALT);
  assign tgt_ok = (redirectTarget <= LAST_PC);

  // A stall re-reads the word currently on the bus so memory output holds steady.
  always_comb begin
    address = pc;
    if (!reset_n)  address = RST_PC;
    else if (hold) address = instrPc;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc         <= RST_PC;
      instrPc    <= '0;
      instrValid <= 1'b0;
      halted     <= 1'b0;
      state      <= RUN;
    end else if (state == HALT) begin
      instrValid <= 1'b0;
      halted     <= 1'b1;
    end else if (stall) begin
      // Redirect alongside a stall is dropped; decode presents it again.
      pc         <= pc;
    end else if (redirect) begin
      // The word fetched this cycle was from the wrong path.
      instrValid <= 1'b0;
      instrPc    <= pc;
      if (tgt_ok) begin
        pc    <= redirectTarget;
        state <= RUN;
      end else begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          instrPc    <= pc;
          instrValid <= 1'b1;
          if (pc < LAST_PC) pc    <= pc + 1'b1;
          else              state <= DRAIN;
        end
        DRAIN: begin
          instrValid <= 1'b0;
          state      <= HALT;
          halted     <= 1'b1;
        end
        default: begin
          instrValid <= 1'b0;
          state      <= HALT;
          halted     <= 1'b1;
        end
      endcase
    end
  end

endmodule
